serial_ripple_subtractor: RTL and testbench

- Bit-serial subtractor: computes diff = a - b - bin over WIDTH clock cycles, one bit per cycle, LSB first, with a single borrow flip-flop.
- It is the inverse-direction companion to the team's combinational ripple-carry adder chain, for area-constrained paths where latency is acceptable.
- Operands enter on a valid/ready input port. The result leaves on a valid/ready output port.

---
 rtl/serial_ripple_subtractor.sv | 146 ++++++++++++++
 tb/tb_serial_ripple_subtractor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor
//   Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), LSB first,
//   one bit per clock, using a single borrow flip-flop.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous reset, active-high
//     in_valid   operands a, b, bin presented
//     in_ready   block is idle and can accept operands
//     a, b       minuend / subtrahend (WIDTH bits)
//     bin        borrow-in
//     out_valid  diff/bout hold a completed result
//     out_ready  consumer accepts the result
//     diff       a - b - bin modulo 2^WIDTH
//     bout       borrow-out (a < b + bin, unsigned)
//
//   Operation: IDLE accepts operands, SHIFT processes WIDTH bits, DONE
//   presents the result until out_ready. The result registers are separate
//   from the working shift register so the last result stays visible in
//   IDLE and during the next operation, until the next result lands.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // One-bit full subtractor on the current LSBs
  logic             x, y, r;
  logic             dbit, bnext;
  logic [WIDTH-1:0] sh_shift;

  always_comb begin
    x        = a_q[0];
    y        = b_q[0];
    r        = borrow_q;
    dbit     = x ^ y ^ r;
    bnext    = (~x & y) | (~(x ^ y) & r);
    // Shift right and insert the new bit at the MSB; written with shifts
    // rather than a slice so WIDTH = 1 stays legal.
    sh_shift = (sh_q >> 1) | (WIDTH'(dbit) << (WIDTH - 1));
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sh_d      = sh_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    bout_d    = bout_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          sh_d     = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        sh_d     = sh_shift;
        borrow_d = bnext;
        cnt_d    = cnt_q + CW'(1);
        // Last bit: publish the completed word and the final borrow
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = sh_shift;
          bout_d  = bnext;
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sh_q     <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sh_q     <= sh_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Testbench for serial_ripple_subtractor: WIDTH=4 directed + exhaustive,
// WIDTH=1 and WIDTH=8 smoke runs with random operands.
module tb_serial_ripple_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH = 4
  logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1;
  logic [3:0] a4 = '0, b4 = '0, diff4;
  logic       bin4 = 1'b0, bout4;

  serial_ripple_subtractor #(.WIDTH(4), .CW(3)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4),
    .out_ready(out_ready4), .diff(diff4), .bout(bout4));

  // WIDTH = 1
  logic in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1;
  logic [0:0] a1 = '0, b1 = '0, diff1;
  logic bin1 = 1'b0, bout1;

  serial_ripple_subtractor #(.WIDTH(1), .CW(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1),
    .out_ready(out_ready1), .diff(diff1), .bout(bout1));

  // WIDTH = 8
  logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic       bin8 = 1'b0, bout8;

  serial_ripple_subtractor #(.WIDTH(8), .CW(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8),
    .out_ready(out_ready8), .diff(diff8), .bout(bout8));

  // Reference: plain integer subtraction; result packed as {bout, diff}
  function automatic int refn(input int w, input int a, input int b, input int bi);
    int r;
    r = a - b - bi;
    return ((r < 0 ? 1 : 0) << w) | (r & ((1 << w) - 1));
  endfunction

  task automatic check(input bit ok, input string nm, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Per-cycle compare for the WIDTH=4 instance against the reference queue
  int  exp_q[$];
  int  acc_q[$];
  bit  vprev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      vprev = 1'b0;
    end else begin
      if (out_valid4) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "cmp_unexpected_valid", 1, 0);
        end else begin
          check({bout4, diff4} == 5'(exp_q[0]), "cmp_result", int'({bout4, diff4}), exp_q[0]);
          if (!vprev) check(cyc == acc_q[0] + 4, "cmp_latency", cyc - acc_q[0], 4);
          check(in_ready4 == 1'b0, "cmp_in_ready_in_done", int'(in_ready4), 0);
          if (out_ready4) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      if (in_valid4 && in_ready4) begin
        exp_q.push_back(refn(4, int'(a4), int'(b4), int'(bin4)));
        acc_q.push_back(cyc + 1);
      end
      vprev = out_valid4;
    end
  end

  // One WIDTH=4 operation; called right after a posedge (+#1).
  task automatic op4(input int a, input int b, input int bi, input int ed,
                     input int eb, input int hold, input string nm);
    int n;
    n = 0;
    while (!in_ready4 && n < 50) begin @(posedge clk); #1; n++; end
    check(in_ready4 == 1'b1, {nm, "_ready_wait"}, int'(in_ready4), 1);
    a4 = 4'(a); b4 = 4'(b); bin4 = bi[0]; in_valid4 = 1'b1;
    out_ready4 = (hold == 0);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 20) begin @(posedge clk); #1; n++; end
    check(out_valid4 == 1'b1 && n == 4, {nm, "_latency"}, n, 4);
    check(diff4 == 4'(ed), {nm, "_diff"}, int'(diff4), ed);
    check(bout4 == eb[0], {nm, "_bout"}, int'(bout4), eb);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check(out_valid4 && !in_ready4 && diff4 == 4'(ed) && bout4 == eb[0],
            {nm, "_hold"}, int'({out_valid4, in_ready4, bout4, diff4}),
            (1 << 6) | (eb << 4) | ed);
    end
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    check(!out_valid4 && in_ready4, {nm, "_back_idle"},
          int'({out_valid4, in_ready4}), 1);
    check(diff4 == 4'(ed) && bout4 == eb[0], {nm, "_retain"},
          int'({bout4, diff4}), (eb << 4) | ed);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, e;
    // Reset state
    #12;
    check(in_ready4 && !out_valid4 && diff4 == 4'd0 && !bout4, "reset_state",
          int'({in_ready4, out_valid4, bout4, diff4}), 64);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic and underflow cases
    op4(9,   3,   0, 6,   0, 0, "basic");
    op4(3,   9,   0, 10,  1, 0, "under1");
    op4(0,   0,   1, 15,  1, 0, "under2");
    op4(15,  15,  0, 0,   0, 0, "equal");
    op4(12,  5,   0, 7,   0, 6, "backpressure");

    // Busy ignore: new operands offered during SHIFT are not captured
    a4 = 4'd8; b4 = 4'd1; bin4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk); #1;
    a4 = 4'd0; b4 = 4'd15;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    n = 2;
    while (!out_valid4 && n < 20) begin @(posedge clk); #1; n++; end
    check(out_valid4 && n == 4, "busy_latency", n, 4);
    check(diff4 == 4'd7 && !bout4, "busy_result", int'({bout4, diff4}), 7);
    @(posedge clk); #1;
    check(!out_valid4 && in_ready4, "busy_back_idle", int'({out_valid4, in_ready4}), 1);

    // Reset mid-operation
    a4 = 4'd5; b4 = 4'd2; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check(!out_valid4 && in_ready4 && diff4 == 4'd0 && !bout4, "mid_reset",
          int'({out_valid4, in_ready4, bout4, diff4}), 16 << 2);
    @(posedge clk); #1;
    rst = 1'b0;
    op4(5, 2, 0, 3, 0, 0, "after_reset");

    // Exhaustive WIDTH=4
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          e = refn(4, ia, ib, ic);
          op4(ia, ib, ic, e & 15, (e >> 4) & 1, 0, "exh");
        end

    // WIDTH=1 smoke
    for (int k = 0; k < 16; k++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
      e = refn(1, int'(a1), int'(b1), int'(bin1));
      in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      n = 0;
      while (!out_valid1 && n < 10) begin @(posedge clk); #1; n++; end
      check(out_valid1 && n == 1, "w1_latency", n, 1);
      check({bout1, diff1} == 2'(e), "w1_result", int'({bout1, diff1}), e);
      @(posedge clk); #1;
      check(!out_valid1 && in_ready1, "w1_back_idle", int'({out_valid1, in_ready1}), 1);
    end

    // WIDTH=8 smoke
    for (int k = 0; k < 16; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      e = refn(8, int'(a8), int'(b8), int'(bin8));
      in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      n = 0;
      while (!out_valid8 && n < 30) begin @(posedge clk); #1; n++; end
      check(out_valid8 && n == 8, "w8_latency", n, 8);
      check({bout8, diff8} == 9'(e), "w8_result", int'({bout8, diff8}), e);
      @(posedge clk); #1;
      check(!out_valid8 && in_ready8, "w8_back_idle", int'({out_valid8, in_ready8}), 1);
    end

    check(exp_q.size() == 0, "cmp_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
